sdram_responder: RTL
====================

Name: sdram_responder

Overview:
- Cycle-accurate responder for the 2M x 32 SDR SDRAM command interface driven by the SoC SDRAM controller (4 banks, 11-bit row, 8-bit column, split DQ read/write/enable).
- Used in simulation and FPGA self-test builds in place of the embedded SDRAM PHY.
- Decodes commands, tracks per-bank open rows, stores write data in a reduced-depth array, and returns read bursts after CAS latency.
- Flags protocol violations through sticky error bits.

Parameters:
- MEM_AW, 12, log2 of stored 32-bit words; the linear address {ba,row,col} is truncated to its low MEM_AW bits (aliasing above this is intended).
- T_RCD, 2, minimum number of cycles from ACTIVE to READ/WRITE on the same bank.
- INIT_MRS_REQUIRED, 1, when 1, any READ/WRITE issued before the first LOAD MODE is an error.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- cke  in  1  when 0, the command is ignored and burst/pipeline state holds.
- cs_n, ras_n, cas_n, we_n  in  1 each  command bits.
- ba  in  2  bank address.
- addr  in  11  row (ACTIVE), column addr[7:0] plus auto-precharge addr[10] (READ/WRITE), mode (LOAD MODE).
- dqm  in  4  byte masks, one per byte lane.
- dq_write  in  32  write data from the controller.
- dq_read  out  32  read data; 0 when not driving.
- dq_writeEnable  out  32  all bits 1 while driving a read beat, else 0.
- error  out  4  sticky flags: [0] access to an idle bank, [1] ACTIVE to an open bank, [2] tRCD violation, [3] unsupported mode or access before MRS.

Behaviour:
- Reset values: dq_read=0, dq_writeEnable=0, error=0, all banks idle, mode invalid (burst length 1, CL 2), burst and CAS pipeline empty. Reset asserted mid-burst aborts it in the same cycle. Array contents are not reset.
- Command decode (cs_n,ras_n,cas_n,we_n): 1xxx=DESELECT, 0111=NOP, 0011=ACTIVE, 0101=READ, 0100=WRITE, 0010=PRECHARGE (addr[10]=1 means all banks), 0001=AUTO REFRESH, 0000=LOAD MODE, 0110=BURST TERMINATE.
- LOAD MODE fields:
  - BL=addr[2:0]: 000/001/010/011 give 1/2/4/8.
  - BT=addr[3]: must be 0 (sequential).
  - CL=addr[6:4]: 2 or 3.
  - addr[9]=1 selects single-location write.
  - Any other encoding sets error[3] and keeps the previous mode.
- Bank state: idle/active with a stored row and a tRCD counter that loads T_RCD-1 on ACTIVE and counts down to 0.
  - ACTIVE to an open bank sets error[1] and replaces the row.
  - PRECHARGE closes the bank (or all banks); PRECHARGE on an idle bank is a legal no-op.
  - AUTO REFRESH with any bank open sets error[0].
- READ/WRITE to an idle bank: set error[0] and drop the access. If tRCD counter is nonzero: set error[2], access still performed.
- Burst sequencing:
  - Column sequence wraps inside the BL-aligned block: col = {start[7:log2BL], (start[log2BL-1:0]+beat) mod BL}.
  - A new READ/WRITE, BURST TERMINATE or PRECHARGE to the bursting bank truncates the running burst in the cycle it is issued; a new access starts immediately.
  - Auto-precharge (addr[10]) closes the bank after the last beat.
- WRITE: beat 0 data is taken in the command cycle; one beat per cycle after that. Byte lane i is written only when dqm[i]=0 in that same cycle (write-mask latency 0).
- READ: the array is read in the command cycle. Beat k appears on dq_read with dq_writeEnable all 1s exactly CL cycles after the beat's issue cycle. This needs a CL-deep pipeline of {valid,data}.
  - Read DQM latency is 2: if dqm (any bit) is high 2 cycles before a beat's output cycle, that beat outputs with enable 0.
  - A truncated read still delivers beats already issued into the pipeline.
- A WRITE issued while read beats are in the pipeline flushes those beats (read-to-write turnaround is the controller's responsibility; no error).
- cke=0: command treated as NOP; burst counter and CAS pipeline freeze.

Decomposition:
- Package sdram_pkg: command opcode constants, mode field positions, BL/CL encodings, error bit indices.
- Sub-module sdram_bank_state (one instance per bank): open flag, row register, tRCD counter, error strobes.
- Top level holds decode, mode register, burst counter, array and CAS pipeline.

Test Plan:
- MRS 0x022 (CL2, BL4), ACTIVE b0 row 5, wait 2, WRITE col 0x10 data 0x11..0x14, READ col 0x12 -> enable rises 2 cycles after READ, data 0x13,0x14,0x11,0x12; error=0.
- MRS CL3 BL8, READ col 7 of an active row -> beats 7,0,1..6 of the 8-block, enable high 8 cycles starting at +3.
- WRITE 0xAABBCCDD with dqm=0b0101 over 0xFFFFFFFF -> read returns 0xAAFFCCFF.
- READ issued 1 cycle after ACTIVE (T_RCD=2) -> error[2]=1; READ to idle bank 2 -> error[0]=1, enable stays 0.
- BL8 read, BURST TERMINATE after beat 2 issued -> exactly 3 beats output; cke=0 for 2 cycles mid-burst -> output stretched, no beats lost.
- Reset asserted during a read burst -> dq_writeEnable=0 next edge, error=0; then MRS BL=111 -> error[3]=1, mode unchanged.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDR SDRAM responder:
// command opcodes, mode register fields, error bits.
package sdram_pkg;

    localparam int NUM_BANKS = 4;
    localparam int PIPE_D    = 3;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_LMR = 4'b0000;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_BST = 4'b0110;
    localparam logic [3:0] CMD_NOP = 4'b0111;

    localparam int MR_BL_LSB = 0;
    localparam int MR_BT_BIT = 3;
    localparam int MR_CL_LSB = 4;
    localparam int MR_OP_LSB = 7;
    localparam int MR_WB_BIT = 9;

    localparam logic [2:0] CL_2 = 3'd2;
    localparam logic [2:0] CL_3 = 3'd3;

    localparam int ERR_IDLE     = 0;
    localparam int ERR_ACT_OPEN = 1;
    localparam int ERR_TRCD     = 2;
    localparam int ERR_MODE     = 3;

    typedef struct packed {
        logic       wb_single;
        logic       cl3;
        logic [1:0] bl_log2;
    } mode_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } rd_beat_t;

    function automatic logic mode_legal(input logic [9:0] a);
        logic cl_ok;
        cl_ok = (a[MR_CL_LSB +: 3] == CL_2) || (a[MR_CL_LSB +: 3] == CL_3);
        return !a[MR_BL_LSB + 2] && !a[MR_BT_BIT] && cl_ok
            && (a[MR_OP_LSB +: 2] == 2'b00);
    endfunction

    function automatic mode_t mode_decode(input logic [9:0] a);
        mode_t m;
        m.wb_single = a[MR_WB_BIT];
        m.cl3       = (a[MR_CL_LSB +: 3] == CL_3);
        m.bl_log2   = a[MR_BL_LSB +: 2];
        return m;
    endfunction

    // Column wraps inside the burst-length aligned block.
    function automatic logic [7:0] wrap_col(
        input logic [7:0] start,
        input logic [2:0] beat,
        input logic [1:0] bl_log2
    );
        logic [7:0] m;
        m = 8'((9'd1 << bl_log2) - 9'd1);
        return (start & ~m) | ((start + {5'd0, beat}) & m);
    endfunction

endpackage

// File: rtl/sdram_bank_state.sv
// Per-bank open/row tracking with the ACTIVE-to-access
// (tRCD) countdown.
module sdram_bank_state #(
    parameter int T_RCD = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        act,
    input  logic        pre,
    input  logic [10:0] row_in,
    output logic        is_open,
    output logic [10:0] row,
    output logic        busy,
    output logic        act_err
);

    localparam int CW = (T_RCD > 1) ? $clog2(T_RCD) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_open <= 1'b0;
            row     <= '0;
            cnt     <= '0;
        end else if (act) begin
            is_open <= 1'b1;
            row     <= row_in;
            cnt     <= CW'(T_RCD - 1);
        end else begin
            if (pre) is_open <= 1'b0;
            if (cnt != '0) cnt <= cnt - 1'b1;
        end
    end

    assign busy    = (cnt != '0);
    assign act_err = act && is_open;

endmodule

// File: rtl/sdram_responder.sv
// Cycle-accurate SDR SDRAM responder: command decode, mode
// register, burst sequencing, storage and CAS pipeline.
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int MEM_AW            = 12,
    parameter int T_RCD             = 2,
    parameter int INIT_MRS_REQUIRED = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cke,
    input  logic        cs_n,
    input  logic        ras_n,
    input  logic        cas_n,
    input  logic        we_n,
    input  logic [1:0]  ba,
    input  logic [10:0] addr,
    input  logic [3:0]  dqm,
    input  logic [31:0] dq_write,
    output logic [31:0] dq_read,
    output logic [31:0] dq_writeEnable,
    output logic [3:0]  error
);

    logic [3:0] cmd;
    logic is_act, is_rd, is_wr, is_pre, is_ref, is_lmr, is_bst;

    assign cmd = (cke && !cs_n) ? {1'b0, ras_n, cas_n, we_n} : CMD_NOP;
    assign is_act = (cmd == CMD_ACT);
    assign is_rd  = (cmd == CMD_RD);
    assign is_wr  = (cmd == CMD_WR);
    assign is_pre = (cmd == CMD_PRE);
    assign is_ref = (cmd == CMD_REF);
    assign is_lmr = (cmd == CMD_LMR);
    assign is_bst = (cmd == CMD_BST);

    logic [NUM_BANKS-1:0] bank_open, bank_busy, bank_act_err;
    logic [NUM_BANKS-1:0] bank_act, bank_pre;
    logic [10:0]          bank_row [NUM_BANKS];
    logic                 ap_close;
    logic [1:0]           ap_bank;

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        assign bank_act[i] = is_act && (ba == 2'(i));
        assign bank_pre[i] = (is_pre && (addr[10] || ba == 2'(i)))
                          || (ap_close && ap_bank == 2'(i));

        sdram_bank_state #(.T_RCD(T_RCD)) u_bank (
            .clk     (clk),
            .reset   (reset),
            .act     (bank_act[i]),
            .pre     (bank_pre[i]),
            .row_in  (addr),
            .is_open (bank_open[i]),
            .row     (bank_row[i]),
            .busy    (bank_busy[i]),
            .act_err (bank_act_err[i])
        );
    end

    mode_t mode_q;
    logic  mrs_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q   <= '0;
            mrs_done <= 1'b0;
        end else if (is_lmr && mode_legal(addr[9:0])) begin
            mode_q   <= mode_decode(addr[9:0]);
            mrs_done <= 1'b1;
        end
    end

    logic acc, acc_open, mrs_ok, acc_ok;
    logic [1:0] new_len;

    assign acc      = is_rd || is_wr;
    assign acc_open = bank_open[ba];
    assign mrs_ok   = (INIT_MRS_REQUIRED == 0) || mrs_done;
    assign acc_ok   = acc && acc_open && mrs_ok;
    assign new_len  = (is_wr && mode_q.wb_single) ? 2'd0
                                                  : mode_q.bl_log2;

    logic        b_act, b_wr, b_ap;
    logic [1:0]  b_bank, b_len;
    logic [10:0] b_row;
    logic [7:0]  b_start;
    logic [2:0]  b_beat, last_beat;
    logic        trunc, cont, at_last;

    assign last_beat = 3'((4'd1 << b_len) - 4'd1);
    assign at_last   = (b_beat == last_beat);
    // Any access, BST or precharge hitting the burst bank cuts it short.
    assign trunc = b_act && (acc || is_bst
                 || (is_pre && (addr[10] || ba == b_bank)));
    assign cont  = b_act && cke && !trunc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_act   <= 1'b0;
            b_wr    <= 1'b0;
            b_ap    <= 1'b0;
            b_bank  <= '0;
            b_len   <= '0;
            b_row   <= '0;
            b_start <= '0;
            b_beat  <= '0;
        end else if (acc_ok) begin
            b_act   <= (new_len != 2'd0);
            b_wr    <= is_wr;
            b_ap    <= addr[10];
            b_bank  <= ba;
            b_len   <= new_len;
            b_row   <= bank_row[ba];
            b_start <= addr[7:0];
            b_beat  <= 3'd1;
        end else if (trunc) begin
            b_act <= 1'b0;
        end else if (cont) begin
            if (at_last) b_act <= 1'b0;
            else         b_beat <= b_beat + 3'd1;
        end
    end

    always_comb begin
        ap_close = 1'b0;
        ap_bank  = ba;
        if (acc_ok && addr[10] && new_len == 2'd0) begin
            ap_close = 1'b1;
        end else if (cont && b_ap && at_last) begin
            ap_close = 1'b1;
            ap_bank  = b_bank;
        end
    end

    logic        beat_en, beat_wr;
    logic [1:0]  beat_bank;
    logic [10:0] beat_row;
    logic [7:0]  beat_col;

    always_comb begin
        beat_en   = 1'b0;
        beat_wr   = 1'b0;
        beat_bank = ba;
        beat_row  = bank_row[ba];
        beat_col  = addr[7:0];
        if (acc_ok) begin
            beat_en = 1'b1;
            beat_wr = is_wr;
        end else if (cont) begin
            beat_en   = 1'b1;
            beat_wr   = b_wr;
            beat_bank = b_bank;
            beat_row  = b_row;
            beat_col  = wrap_col(b_start, b_beat, b_len);
        end
    end

    logic [20:0]       lin;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem [2**MEM_AW];
    logic [31:0]       rd_data;

    // Upper address bits alias onto the reduced array.
    assign lin      = {beat_bank, beat_row, beat_col};
    assign mem_addr = MEM_AW'(lin);
    assign rd_data  = mem[mem_addr];

    always_ff @(posedge clk) begin
        if (beat_en && beat_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (!dqm[i]) mem[mem_addr][8*i +: 8] <= dq_write[8*i +: 8];
            end
        end
    end

    rd_beat_t pipe [PIPE_D];
    rd_beat_t issue, out_beat;
    logic     dqm_any;

    assign issue   = '{valid: beat_en && !beat_wr, data: rd_data};
    assign dqm_any = |dqm;

    // Read DQM masks the beat two cycles ahead of its output slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_D; i++) pipe[i] <= '0;
        end else if (is_wr) begin
            for (int i = 0; i < PIPE_D; i++) pipe[i].valid <= 1'b0;
        end else if (cke) begin
            pipe[0] <= issue;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
            if (mode_q.cl3) pipe[1].valid <= pipe[0].valid && !dqm_any;
            else            pipe[0].valid <= issue.valid && !dqm_any;
        end
    end

    assign out_beat       = mode_q.cl3 ? pipe[2] : pipe[1];
    assign dq_writeEnable = {32{out_beat.valid}};
    assign dq_read        = out_beat.valid ? out_beat.data : '0;

    logic [3:0] err_set;

    always_comb begin
        err_set               = '0;
        err_set[ERR_IDLE]     = (acc && !acc_open)
                             || (is_ref && (|bank_open));
        err_set[ERR_ACT_OPEN] = |bank_act_err;
        err_set[ERR_TRCD]     = acc && acc_open && bank_busy[ba];
        err_set[ERR_MODE]     = (is_lmr && !mode_legal(addr[9:0]))
                             || (acc && !mrs_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) error <= '0;
        else       error <= error | err_set;
    end

endmodule
